iq_sweep_controller: RTL and testbench

// Sequences a stepped-frequency sweep on one IQModule: drives its NCO phaseInc through

---
 rtl/iq_sweep_controller_if.sv | 35 +++
 rtl/iq_sweep_controller.sv | 185 ++++++++++++++++++
 tb/tb_iq_sweep_controller.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/iq_sweep_controller_if.sv
// Control, sample and point signals between the sweep controller and its surroundings.
// The controller sits on the slave side; the top level or bench drives the master side.
interface iq_sweep_controller_if #(
  parameter int PHASE_W  = 32,
  parameter int DATA_W   = 14,
  parameter int SETTLE_W = 20,
  parameter int STEP_W   = 10
);
  logic                       start;
  logic                       abort;
  logic [PHASE_W-1:0]         phaseStart;
  logic [PHASE_W-1:0]         phaseStep;
  logic [STEP_W-1:0]          numSteps;
  logic [SETTLE_W-1:0]        settleCycles;
  logic                       filtValid;
  logic signed [DATA_W-1:0]   I;
  logic signed [DATA_W-1:0]   Q;
  logic [PHASE_W-1:0]         phaseInc;
  logic                       busy;
  logic                       pointValid;
  logic [STEP_W-1:0]          pointIndex;
  logic signed [DATA_W-1:0]   pointI;
  logic signed [DATA_W-1:0]   pointQ;
  logic                       done;

  modport master (
    output start, abort, phaseStart, phaseStep, numSteps, settleCycles, filtValid, I, Q,
    input  phaseInc, busy, pointValid, pointIndex, pointI, pointQ, done
  );

  modport slave (
    input  start, abort, phaseStart, phaseStep, numSteps, settleCycles, filtValid, I, Q,
    output phaseInc, busy, pointValid, pointIndex, pointI, pointQ, done
  );
endinterface

// File: rtl/iq_sweep_controller.sv
// Stepped-frequency sweep sequencer: steps the NCO phase increment, waits for the FIR to
// settle, averages 2^AVG_LOG2 filtered I/Q samples and emits one averaged point per step.
module iq_sweep_controller #(
  parameter int PHASE_W  = 32,
  parameter int DATA_W   = 14,
  parameter int SETTLE_W = 20,
  parameter int STEP_W   = 10,
  parameter int AVG_LOG2 = 4
) (
  input logic                  CLK,
  input logic                  reset_n,
  iq_sweep_controller_if.slave bus
);

  localparam int ACC_W = DATA_W + AVG_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACCUM, S_EMIT, S_DONE} state_t;

  state_t state_q, state_d;

  logic [PHASE_W-1:0]       phase_step_q, phase_step_d;
  logic [PHASE_W-1:0]       phase_inc_q, phase_inc_d;
  logic [STEP_W-1:0]        num_steps_q, num_steps_d;
  logic [STEP_W-1:0]        idx_q, idx_d;
  logic [STEP_W-1:0]        point_index_q, point_index_d;
  logic [SETTLE_W-1:0]      settle_cycles_q, settle_cycles_d;
  logic [SETTLE_W-1:0]      cnt_q, cnt_d;
  logic [AVG_LOG2-1:0]      sample_cnt_q, sample_cnt_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0]  acc_q_q, acc_q_d;
  logic signed [DATA_W-1:0] point_i_q, point_i_d;
  logic signed [DATA_W-1:0] point_q_q, point_q_d;
  logic                     busy_q, busy_d;
  logic                     point_valid_q, point_valid_d;
  logic                     done_q, done_d;

  logic signed [ACC_W-1:0]  sum_i;
  logic signed [ACC_W-1:0]  sum_q;
  logic                     abort_now;
  logic                     start_ok;
  logic                     last_sample;
  logic                     last_point;

  // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples, so it never overflows.
  assign sum_i       = acc_i_q + {{AVG_LOG2{bus.I[DATA_W-1]}}, bus.I};
  assign sum_q       = acc_q_q + {{AVG_LOG2{bus.Q[DATA_W-1]}}, bus.Q};
  assign abort_now   = bus.abort && (state_q != S_IDLE);
  assign start_ok    = bus.start && !bus.abort;
  assign last_sample = (sample_cnt_q == {AVG_LOG2{1'b1}});
  assign last_point  = (idx_q == (num_steps_q - STEP_W'(1)));

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_now) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start_ok) state_d = (bus.numSteps != '0) ? S_SETTLE : S_DONE;
        S_SETTLE: if (cnt_q == '0) state_d = S_ACCUM;
        S_ACCUM:  if (bus.filtValid && last_sample) state_d = S_EMIT;
        S_EMIT:   state_d = last_point ? S_DONE : S_SETTLE;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Status flags are decoded from the next state so they line up with the state register.
  always_comb begin
    busy_d        = (state_d != S_IDLE);
    point_valid_d = (state_d == S_EMIT);
    done_d        = (state_d == S_DONE);
  end

  always_comb begin
    phase_step_d    = phase_step_q;
    phase_inc_d     = phase_inc_q;
    num_steps_d     = num_steps_q;
    idx_d           = idx_q;
    point_index_d   = point_index_q;
    settle_cycles_d = settle_cycles_q;
    cnt_d           = cnt_q;
    sample_cnt_d    = sample_cnt_q;
    acc_i_d         = acc_i_q;
    acc_q_d         = acc_q_q;
    point_i_d       = point_i_q;
    point_q_d       = point_q_q;
    if (!abort_now) begin
      case (state_q)
        S_IDLE: begin
          if (start_ok && (bus.numSteps != '0)) begin
            phase_step_d    = bus.phaseStep;
            num_steps_d     = bus.numSteps;
            settle_cycles_d = bus.settleCycles;
            phase_inc_d     = bus.phaseStart;
            idx_d           = '0;
            cnt_d           = bus.settleCycles;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            acc_i_d      = '0;
            acc_q_d      = '0;
            sample_cnt_d = '0;
          end else begin
            cnt_d = cnt_q - SETTLE_W'(1);
          end
        end
        S_ACCUM: begin
          if (bus.filtValid) begin
            acc_i_d      = sum_i;
            acc_q_d      = sum_q;
            sample_cnt_d = sample_cnt_q + AVG_LOG2'(1);
            if (last_sample) begin
              point_i_d     = DATA_W'(sum_i >>> AVG_LOG2);
              point_q_d     = DATA_W'(sum_q >>> AVG_LOG2);
              point_index_d = idx_q;
            end
          end
        end
        S_EMIT: begin
          if (!last_point) begin
            phase_inc_d = phase_inc_q + phase_step_q;
            idx_d       = idx_q + STEP_W'(1);
            cnt_d       = settle_cycles_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      phase_step_q    <= '0;
      phase_inc_q     <= '0;
      num_steps_q     <= '0;
      idx_q           <= '0;
      point_index_q   <= '0;
      settle_cycles_q <= '0;
      cnt_q           <= '0;
      sample_cnt_q    <= '0;
      acc_i_q         <= '0;
      acc_q_q         <= '0;
      point_i_q       <= '0;
      point_q_q       <= '0;
      busy_q          <= 1'b0;
      point_valid_q   <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      phase_step_q    <= phase_step_d;
      phase_inc_q     <= phase_inc_d;
      num_steps_q     <= num_steps_d;
      idx_q           <= idx_d;
      point_index_q   <= point_index_d;
      settle_cycles_q <= settle_cycles_d;
      cnt_q           <= cnt_d;
      sample_cnt_q    <= sample_cnt_d;
      acc_i_q         <= acc_i_d;
      acc_q_q         <= acc_q_d;
      point_i_q       <= point_i_d;
      point_q_q       <= point_q_d;
      busy_q          <= busy_d;
      point_valid_q   <= point_valid_d;
      done_q          <= done_d;
    end
  end

  assign bus.phaseInc   = phase_inc_q;
  assign bus.busy       = busy_q;
  assign bus.pointValid = point_valid_q;
  assign bus.pointIndex = point_index_q;
  assign bus.pointI     = point_i_q;
  assign bus.pointQ     = point_q_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_iq_sweep_controller.sv
// Directed bench for the sweep controller: timing, averaging, gating, abort, wrap and reset.
module tb_iq_sweep_controller;

  logic CLK;
  logic reset_n;

  iq_sweep_controller_if bus ();

  iq_sweep_controller dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  int                 npts;
  int                 done_e;
  int                 idle_e;
  int                 pv_e   [8];
  logic [9:0]         pv_idx [8];
  logic signed [13:0] pv_i   [8];
  logic signed [13:0] pv_q   [8];
  logic [31:0]        pv_ph  [8];
  int                 done_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // mode 0: filtValid=1, I const; 1: filtValid=1, I alternates 1,-2; 2: filtValid 1 in 3 of ACCUM; 3: filtValid=0
  task automatic run_sweep(input logic [31:0] ps, input logic [31:0] st, input int n, input int settle,
                           input int mode, input logic signed [13:0] ival, input logic signed [13:0] qval,
                           input int rp, input int max_e);
    npts   = 0;
    done_e = -1;
    idle_e = -1;
    bus.phaseStart   = ps;
    bus.phaseStep    = st;
    bus.numSteps     = 10'(n);
    bus.settleCycles = 20'(settle);
    for (int e = 0; e <= max_e && idle_e < 0; e++) begin
      bus.start = (e == 0) || (e == rp);
      if (rp >= 0 && e == 1) begin
        bus.phaseStart   = 32'h1234_5678;
        bus.phaseStep    = 32'h0BAD_0000;
        bus.numSteps     = 10'd7;
        bus.settleCycles = 20'd1;
      end
      case (mode)
        2:       bus.filtValid = (e >= settle + 2) && (((e - settle - 2) % 3) == 2);
        3:       bus.filtValid = 1'b0;
        default: bus.filtValid = 1'b1;
      endcase
      bus.I = (mode == 1) ? ((e % 2 == 1) ? -14'sd2 : 14'sd1) : ival;
      bus.Q = qval;
      tick();
      if (bus.pointValid && npts < 8) begin
        pv_e[npts]   = e;
        pv_idx[npts] = bus.pointIndex;
        pv_i[npts]   = bus.pointI;
        pv_q[npts]   = bus.pointQ;
        pv_ph[npts]  = bus.phaseInc;
        $display("point edge=%0d idx=%0d I=%0d Q=%0d phaseInc=%0h", e, bus.pointIndex,
                 bus.pointI, bus.pointQ, bus.phaseInc);
        npts++;
      end
      if (bus.done) done_e = e;
      if (!bus.busy) idle_e = e;
    end
    bus.start     = 1'b0;
    bus.filtValid = 1'b0;
    $display("sweep n=%0d settle=%0d mode=%0d points=%0d done_edge=%0d idle_edge=%0d",
             n, settle, mode, npts, done_e, idle_e);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.phaseStart   = '0;
    bus.phaseStep    = '0;
    bus.numSteps     = '0;
    bus.settleCycles = '0;
    bus.filtValid    = 1'b0;
    bus.I            = '0;
    bus.Q            = '0;
    repeat (3) tick();
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_phase", 64'(bus.phaseInc), 0);
    check("rst_pv", 64'(bus.pointValid), 0);
    check("rst_done", 64'(bus.done), 0);
    check("rst_pi", 64'(bus.pointI), 0);
    reset_n = 1'b1;
    tick();

    // Basic three-point sweep
    run_sweep(32'd85899346, 32'd8589935, 3, 10, 0, 14'sd100, -14'sd50, -1, 120);
    check("sw_npts", npts, 3);
    check("sw_e0", pv_e[0], 27);
    check("sw_e1", pv_e[1], 55);
    check("sw_e2", pv_e[2], 83);
    check("sw_idx1", pv_idx[1], 1);
    check("sw_idx2", pv_idx[2], 2);
    check("sw_i0", pv_i[0], 100);
    check("sw_q2", pv_q[2], -50);
    check("sw_ph0", pv_ph[0], 32'd85899346);
    check("sw_ph1", pv_ph[1], 32'd94489281);
    check("sw_ph2", pv_ph[2], 32'd103079216);
    check("sw_done", done_e, 84);
    check("sw_idle", idle_e, 85);
    tick();

    // Averaging: floor of -0.5, and both full-scale extremes
    run_sweep(32'd1, 32'd1, 1, 2, 1, 14'sd0, -14'sd8192, -1, 60);
    check("avg_e", pv_e[0], 19);
    check("avg_i", pv_i[0], -1);
    check("avg_qmin", pv_q[0], -8192);
    run_sweep(32'd1, 32'd1, 1, 2, 0, 14'sd7, 14'sd8191, -1, 60);
    check("avg_qmax", pv_q[0], 8191);
    check("avg_i7", pv_i[0], 7);

    // Gated filtValid: 16 samples spread over 48 ACCUM cycles
    run_sweep(32'd5, 32'd1, 1, 10, 2, 14'sd3, 14'sd4, -1, 120);
    check("gate_e", pv_e[0], 59);
    check("gate_i", pv_i[0], 3);

    // filtValid held low: stays in ACCUM, then abort
    run_sweep(32'hABCD_0000, 32'd1, 1, 0, 3, 14'sd0, 14'sd0, -1, 40);
    check("hold_npts", npts, 0);
    check("hold_busy", 64'(bus.busy), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 0);
    check("abort_done", 64'(bus.done), 0);
    check("abort_phase", 64'(bus.phaseInc), 32'hABCD_0000);
    check("abort_pi", 64'(bus.pointI), 3);
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.done || bus.pointValid) done_seen++;
    end
    check("abort_quiet", done_seen, 0);

    // start together with abort in IDLE launches nothing
    bus.numSteps = 10'd1;
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_busy", 64'(bus.busy), 0);

    // Phase increment wraps modulo 2^32
    run_sweep(32'hFFFF_FFF0, 32'h20, 2, 1, 0, 14'sd0, 14'sd0, -1, 80);
    check("wrap_npts", npts, 2);
    check("wrap_ph0", pv_ph[0], 32'hFFFF_FFF0);
    check("wrap_ph1", pv_ph[1], 32'h0000_0010);

    // numSteps=0: immediate done, no points, phaseInc unchanged
    run_sweep(32'h5555_5555, 32'h1, 0, 4, 0, 14'sd0, 14'sd0, -1, 20);
    check("z_done", done_e, 0);
    check("z_idle", idle_e, 1);
    check("z_npts", npts, 0);
    check("z_phase", 64'(bus.phaseInc), 32'h0000_0010);

    // start re-pulsed mid-sweep with changed config: ignored
    run_sweep(32'd1000, 32'd100, 2, 3, 0, 14'sd9, 14'sd9, 5, 100);
    check("rp_npts", npts, 2);
    check("rp_e0", pv_e[0], 20);
    check("rp_e1", pv_e[1], 41);
    check("rp_ph1", pv_ph[1], 32'd1100);
    check("rp_done", done_e, 42);

    // settleCycles=0: SETTLE lasts one cycle
    run_sweep(32'd2, 32'd1, 1, 0, 0, 14'sd1, 14'sd1, -1, 40);
    check("s0_e", pv_e[0], 17);

    // Reset asserted mid-sweep
    run_sweep(32'h7777_0000, 32'd1, 2, 0, 3, 14'sd0, 14'sd0, -1, 10);
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("mrst_busy", 64'(bus.busy), 0);
    check("mrst_phase", 64'(bus.phaseInc), 0);
    check("mrst_pi", 64'(bus.pointI), 0);
    check("mrst_pq", 64'(bus.pointQ), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
